// File: rtl/trunc_sat_pipe.sv
// trunc_sat_pipe: 2-stage round/truncate and saturate for a 2N-bit product.
// Optional counter enabled by macro TRUNC_SAT_CNT_EN.
module trunc_sat_pipe #(
    parameter int N     = 25,
    parameter int FRAC  = 20,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*N-1:0]     din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               round_en,
    output logic [N-1:0]       dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               sat_pos,
    output logic               sat_neg,
    output logic [CNT_W-1:0]   sat_count,
    input  logic               cnt_clr
);

    localparam int TW = 2*N + 1;
    localparam int HW = TW - FRAC;
    localparam logic [TW-1:0] HALF = TW'(1) << (FRAC-1);
    localparam logic [N-1:0] MAXC = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINC = {1'b1, {(N-1){1'b0}}};

    logic            stall;
    logic [HW-1:0]   t_hi;
    logic [FRAC-1:0] unused_t_lo;
    logic            s1_valid;
    logic [HW-1:0]   s1_hi;
    logic [HW-N:0]   hi_part;
    logic            in_range;

    assign stall     = dout_valid & ~dout_ready;
    assign din_ready = ~stall;

    // Sign-extend and add the rounding half-LSB; fraction bits below the
    // output LSB are dropped, which floors toward minus infinity.
    assign {t_hi, unused_t_lo} = {din[2*N-1], din} + (round_en ? HALF : '0);

    // S1: hold the rounded intermediate, frozen while the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hi    <= '0;
        end else if (!stall) begin
            s1_valid <= din_valid;
            s1_hi    <= t_hi;
        end
    end

    assign hi_part  = s1_hi[HW-1:N-1];
    assign in_range = (&hi_part) | ~(|hi_part);

    // S2: clamp out-of-range values and register the result with its flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            sat_pos    <= 1'b0;
            sat_neg    <= 1'b0;
        end else if (!stall) begin
            dout_valid <= s1_valid;
            sat_pos    <= s1_valid & ~in_range & ~s1_hi[HW-1];
            sat_neg    <= s1_valid & ~in_range & s1_hi[HW-1];
            if (in_range) begin
                dout <= s1_hi[N-1:0];
            end else if (s1_hi[HW-1]) begin
                dout <= MINC;
            end else begin
                dout <= MAXC;
            end
        end
    end

`ifdef TRUNC_SAT_CNT_EN
    // Count delivered saturated results; sticky at all-ones, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (cnt_clr) begin
            sat_count <= '0;
        end else if (dout_valid && dout_ready && (sat_pos || sat_neg)
                     && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sat_count      = '0;
`endif

endmodule

// File: tb/tb_trunc_sat_pipe.sv
// tb_trunc_sat_pipe: directed vectors for trunc_sat_pipe (N=25, FRAC=20).
// Counter expectations follow TRUNC_SAT_CNT_EN.
module tb_trunc_sat_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [49:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        round_en = 1'b0;
    logic [24:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        sat_pos;
    logic        sat_neg;
    logic [15:0] sat_count;
    logic        cnt_clr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] exp_cnt = '0;

`ifdef TRUNC_SAT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    trunc_sat_pipe #(.N(25), .FRAC(20), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .round_en   (round_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat_pos    (sat_pos),
        .sat_neg    (sat_neg),
        .sat_count  (sat_count),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cnt_exp();
        return CNT_ON ? exp_cnt : 16'h0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    // One sample into an empty pipe; checks 2-cycle latency and result.
    task automatic send_one(input string tag, input longint v, input bit rnd,
                            input logic [24:0] e, input bit ep, input bit en);
        @(negedge clk);
        din = v[49:0];
        round_en = rnd;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        chk({tag, "_lat"}, 64'(dout_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 64'(dout_valid), 64'd1);
        chk({tag, "_dout"}, 64'(dout), 64'(e));
        chk({tag, "_sp"}, 64'(sat_pos), 64'(ep));
        chk({tag, "_sn"}, 64'(sat_neg), 64'(en));
        if ((ep || en) && exp_cnt != 16'hFFFF) exp_cnt++;
    endtask

    longint SATP;
    longint SATN;
    longint bp_in [4];
    logic [24:0] bp_exp [4];

    initial begin
        SATP = longint'(40) <<< 40;
        SATN = -(longint'(40) <<< 40);

        #2;
        chk("rst_vld", 64'(dout_valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_sat", 64'({sat_pos, sat_neg}), 64'd0);
        chk("rst_rdy", 64'(din_ready), 64'd1);
        chk("rst_cnt", 64'(sat_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 64'(din_ready), 64'd1);

        send_one("inr", longint'(3) <<< 40, 1'b0, 25'h0300000, 1'b0, 1'b0);
        send_one("satp", SATP, 1'b0, 25'h0FFFFFF, 1'b1, 1'b0);
        send_one("satn", SATN, 1'b0, 25'h1000000, 1'b0, 1'b1);
        idle(1);
        chk("cnt2", 64'(sat_count), 64'(cnt_exp()));

        send_one("trn", longint'(1) <<< 19, 1'b0, 25'h0, 1'b0, 1'b0);
        send_one("rnd", longint'(1) <<< 19, 1'b1, 25'h1, 1'b0, 1'b0);
        send_one("carry", (longint'(24'hFFFFFF) <<< 20) + (longint'(1) <<< 19),
                 1'b1, 25'h0FFFFFF, 1'b1, 1'b0);
        send_one("ntrn", -(longint'(1) <<< 19), 1'b0, 25'h1FFFFFF, 1'b0, 1'b0);
        send_one("nrnd", -(longint'(1) <<< 19), 1'b1, 25'h0, 1'b0, 1'b0);
        send_one("maxin", longint'(24'hFFFFFF) <<< 20, 1'b0, 25'h0FFFFFF,
                 1'b0, 1'b0);
        send_one("minin", -(longint'(1) <<< 44), 1'b0, 25'h1000000, 1'b0, 1'b0);
        send_one("minm1", -(longint'(1) <<< 44) - 1, 1'b0, 25'h1000000,
                 1'b0, 1'b1);
        idle(2);
        chk("cnt4", 64'(sat_count), 64'(cnt_exp()));

        // Back-pressure: 4 back-to-back samples, dout_ready low 3 cycles.
        bp_in[0] = longint'(1) <<< 40; bp_exp[0] = 25'h0100000;
        bp_in[1] = longint'(2) <<< 40; bp_exp[1] = 25'h0200000;
        bp_in[2] = -(longint'(1) <<< 40); bp_exp[2] = 25'h1F00000;
        bp_in[3] = longint'(5) <<< 40; bp_exp[3] = 25'h0500000;
        begin
            int idx = 0;
            int got = 0;
            int stalls = 0;
            logic [24:0] held = '0;
            for (int c = 0; c < 30 && got < 4; c++) begin
                @(negedge clk);
                dout_ready = !(c >= 2 && c < 5);
                din_valid = (idx < 4);
                din = bp_in[idx < 4 ? idx : 3][49:0];
                round_en = 1'b0;
                #1;
                if (dout_valid && !dout_ready) begin
                    chk("bp_rdy", 64'(din_ready), 64'd0);
                    if (stalls > 0) chk("bp_hold", 64'(dout), 64'(held));
                    held = dout;
                    stalls++;
                end
                if (dout_valid && dout_ready) begin
                    chk("bp_dout", 64'(dout), 64'(bp_exp[got]));
                    got++;
                end
                if (din_valid && din_ready) idx++;
            end
            chk("bp_got", 64'(got), 64'd4);
            chk("bp_stalls", 64'(stalls), 64'd3);
        end
        dout_ready = 1'b1;
        idle(3);

`ifdef TRUNC_SAT_CNT_EN
        @(negedge clk);
        din = SATP[49:0];
        din_valid = 1'b1;
        repeat (65536) @(negedge clk);
        din_valid = 1'b0;
        idle(3);
        exp_cnt = 16'hFFFF;
        chk("cnt_full", 64'(sat_count), 64'(cnt_exp()));
`endif
        send_one("stick", SATP, 1'b0, 25'h0FFFFFF, 1'b1, 1'b0);
        idle(1);
        chk("cnt_stick", 64'(sat_count), 64'(cnt_exp()));
        send_one("clrsat", SATN, 1'b0, 25'h1000000, 1'b0, 1'b1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_cnt = '0;
        chk("cnt_clr", 64'(sat_count), 64'(cnt_exp()));

        // Reset with two samples in flight.
        @(negedge clk);
        din = SATP[49:0];
        din_valid = 1'b1;
        @(negedge clk);
        din = longint'(3) <<< 40;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(dout_valid), 64'd0);
        chk("ar_dout", 64'(dout), 64'd0);
        chk("ar_sat", 64'({sat_pos, sat_neg}), 64'd0);
        chk("ar_cnt", 64'(sat_count), 64'd0);
        chk("ar_rdy", 64'(din_ready), 64'd1);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_stale", 64'(dout_valid), 64'd0);
        end
        send_one("post", longint'(7) <<< 40, 1'b0, 25'h0700000, 1'b0, 1'b0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trunc_sat_pipe.md
TRUNC_SAT_PIPE -- requirements
Module: trunc_sat_pipe

Interface
REQ-001 Parameter N, default 25: output word width; signed fixed point with 1 sign bit, N-1-FRAC integer bits and FRAC fraction bits.
REQ-002 Parameter FRAC, default 20: fraction bits of the output word; each input product carries 2*FRAC fraction bits.
REQ-003 Parameter CNT_W, default 16: width of the saturation event counter.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: asynchronous reset, active-low.
REQ-006 din  input  2N: signed two's-complement product, binary point between bits 2*FRAC and 2*FRAC-1.
REQ-007 din_valid  input  1: din is valid this cycle.
REQ-008 din_ready  output  1: block accepts din this cycle.
REQ-009 round_en  input  1: 1 selects round-half-up; 0 selects truncate toward minus infinity. Sampled with din.
REQ-010 dout  output  N: resized, saturated result.
REQ-011 dout_valid  output  1: dout is valid.
REQ-012 dout_ready  input  1: downstream accepts dout.
REQ-013 sat_pos, sat_neg  output  1 each: dout was clamped to the max or min code. Aligned with dout.
REQ-014 sat_count  output  CNT_W: number of saturated results delivered.
REQ-015 cnt_clr  input  1: synchronous clear of sat_count.

Function
REQ-016 The block SHALL be a 2-stage pipeline: S1 registers the rounded intermediate and S2 registers saturation and output. An accepted sample appears on dout exactly 2 cycles after acceptance when there is no stall.
REQ-017 A transfer SHALL occur on an edge where valid and ready are both 1; this applies at both ports.
REQ-018 The stall condition SHALL be stall = dout_valid & ~dout_ready, and din_ready SHALL equal ~stall.
REQ-019 While stalled, S1 and S2 contents and dout, sat_pos and sat_neg SHALL hold; no sample is lost or duplicated.
REQ-020 A pipeline bubble (din_valid=0 while not stalled) SHALL propagate as valid=0 and SHALL NOT block later samples.
REQ-021 S1 SHALL compute t = sign-extended din (2N+1 bits) plus (round_en ? 2^(FRAC-1) : 0).
REQ-022 S2 SHALL use the candidate bits t[FRAC+N-1:FRAC]; the result is in range iff t[2N:FRAC+N-1] are all equal.
REQ-023 If the result is in range, dout SHALL equal the candidate.
REQ-024 If the result is out of range and t[2N]=0, dout SHALL be 0 followed by N-1 ones, and sat_pos SHALL be 1.
REQ-025 If the result is out of range and t[2N]=1, dout SHALL be 1 followed by N-1 zeros, and sat_neg SHALL be 1.
REQ-026 Rounding carry SHALL be covered by the REQ-022 range check; no wrap-around is permitted.
REQ-027 sat_count SHALL increment by 1 on each output transfer with sat_pos or sat_neg set, and SHALL stick at 2^CNT_W-1.
REQ-028 cnt_clr SHALL have priority over a simultaneous increment: sat_count becomes 0.

Reset
REQ-029 While rst_n=0, all pipeline registers, dout, dout_valid, sat_pos, sat_neg and sat_count SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard all in-flight samples. The first sample accepted after release follows REQ-016.
REQ-031 din_ready SHALL be 1 during reset and immediately after release.

Configuration
REQ-032 Macro TRUNC_SAT_CNT_EN, when defined, SHALL compile in the sat_count register and its logic per REQ-027 and REQ-028.
REQ-033 When TRUNC_SAT_CNT_EN is undefined, sat_count SHALL be constant 0, cnt_clr SHALL be ignored, and no counter flops SHALL exist. The ports remain present.

Verification (N=25, FRAC=20, dout_ready=1 unless stated)
REQ-034 Scenario in range: din=3.0*2^40, round_en=0 -> dout=0x0300000 two cycles later, sat_pos=sat_neg=0.
REQ-035 Scenario saturation: din=40.0*2^40 -> dout=0x0FFFFFF with sat_pos=1; then din=-40.0*2^40 -> dout=0x1000000 with sat_neg=1; sat_count=2.
REQ-036 Scenario rounding: din=2^19 -> dout=0 with round_en=0 and dout=1 with round_en=1. Then din=(0x0FFFFFF<<20)+2^19 with round_en=1 -> dout=0x0FFFFFF and sat_pos=1 (carry clamp).
REQ-037 Scenario back-pressure: drive 4 back-to-back samples and hold dout_ready=0 for 3 cycles -> din_ready=0 while dout_valid=1, dout stable, and all 4 results delivered in order after release.
REQ-038 Scenario counter: preload sat_count to 2^16-1 via saturating inputs, then one more saturation -> stays 0xFFFF. Assert cnt_clr together with a saturated transfer -> 0.
REQ-039 Scenario reset: assert rst_n=0 with 2 samples in flight -> dout_valid=0 and all outputs 0 asynchronously; no stale output after release.
